pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Parametrised program sequencer for the single-cycle microcontroller datapath.
- Replaces the fixed 10-bit PC and the single return-address register with:
  - a PC of configurable width,
  - a hardware call/return stack of configurable depth,
  - sticky stack-error reporting.
- Drives the program-memory address.
- Control inputs come from the main control unit; the immediate comes from the instruction word.

Parameters:
PC_W, 10, width of PC, immediate and stack entries
STACK_DEPTH, 8, number of return-address entries (>=1; 1 reproduces single-register behaviour)
RESET_VEC, 0, PC value after reset
INT_VEC, 1, PC loaded on interrupt entry (only used with PC_SEQ_IRQ_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  1 = update this cycle; 0 = hold all state (stall)
s_inc  input  1  1 = PC + step; 0 = absolute load of imm
s_rel  input  1  step select when s_inc=1: 0 = +1, 1 = +imm (two's complement)
s_call  input  1  push PC+1, load imm
s_ret  input  1  pop top of stack into PC
imm  input  PC_W  jump target / relative offset
pc  output  PC_W  current program address
sp  output  $clog2(STACK_DEPTH+1)  entries in use
stack_empty  output  1  sp == 0
stack_full  output  1  sp == STACK_DEPTH
stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_VEC, sp=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- All updates occur on the rising clk edge with en=1. With en=0, pc, sp, stack and flags hold.
- Priority per cycle: s_ret > s_call > normal flow.
- Normal flow:
  - pc <= s_inc ? (pc + (s_rel ? imm : 1)) : imm.
  - Addition is modulo 2^PC_W; wrap-around is legal and silent.
- Call, stack not full:
  - stack[sp] <= pc+1 (mod 2^PC_W); sp <= sp+1; pc <= imm.
  - s_inc/s_rel are ignored.
- Call, stack full (overflow):
  - no push, no jump; pc <= pc+1; stack_err <= 1.
- Ret, stack not empty: pc <= stack[sp-1]; sp <= sp-1.
- Ret, stack empty (underflow): pc <= pc+1; stack_err <= 1.
- s_call and s_ret together: s_ret only; s_call is dropped without error.
- stack_err is cleared only by reset.
- Latency: pc is registered, so the new address is visible the cycle after the control inputs.
- stack_empty and stack_full are combinational decodes of sp.
- Reset asserted mid-call/ret discards the in-flight update.

Optional Feature:
- Macro: PC_SEQ_IRQ_EN.
- When defined, adds ports:
  - irq (input, 1, level request),
  - irq_ack (output, 1, one-cycle pulse),
  - in_isr (output, 1).
- Interrupt entry, when irq=1, en=1, in_isr=0, stack not full, and neither s_call nor s_ret asserted:
  - push the address normal flow would have produced;
  - pc <= INT_VEC; in_isr <= 1; irq_ack pulses high for that cycle.
- irq while in_isr=1, or while the stack is full, is held pending (not lost, no error).
- s_ret while in_isr=1 pops normally and clears in_isr. A single nesting level is supported.
- Reset: in_isr=0, irq_ack=0.
- When the macro is not defined: ports absent; behaviour exactly as above.

Test Plan:
- Reset then en=1, s_inc=1, s_rel=0 for 3 cycles -> pc = 0,1,2,3; stack_empty=1, sp=0.
- pc=5, s_inc=1, s_rel=1, imm=10'h3FE (-2) -> pc=3. pc=1023, +1 -> pc=0 with no flag.
- Nested calls at pc=4 (imm=100) and pc=100 (imm=200), then two rets -> pc 100, 200, 101, 5; sp 1, 2, 1, 0.
- STACK_DEPTH=2: three calls -> third: pc=old pc+1, sp=2, stack_full=1, stack_err=1. Further cycles: stack_err stays 1 until reset.
- Ret with sp=0 at pc=7 -> pc=8, stack_err=1. s_call and s_ret together with sp=1 -> pop only, sp=0.
- PC_SEQ_IRQ_EN, pc=20, s_inc=1, irq=1 -> pc=INT_VEC, irq_ack=1 for one cycle, in_isr=1. Second irq is ignored. s_ret -> pc=21, in_isr=0. en=0 during irq -> no entry until en=1.

Source files
------------

// File: rtl/pc_seq.sv
// Program sequencer: PC of width PC_W with a hardware call/return stack
// of STACK_DEPTH entries and sticky overflow/underflow reporting.
// Optional interrupt entry is compiled in with `define PC_SEQ_IRQ_EN.
module pc_seq #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_VEC   = 0,
    parameter int INT_VEC     = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic                                 s_inc,
    input  logic                                 s_rel,
    input  logic                                 s_call,
    input  logic                                 s_ret,
    input  logic [PC_W-1:0]                      imm,
`ifdef PC_SEQ_IRQ_EN
    input  logic                                 irq,
    output logic                                 irq_ack,
    output logic                                 in_isr,
`endif
    output logic [PC_W-1:0]                      pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     sp,
    output logic                                 stack_empty,
    output logic                                 stack_full,
    output logic                                 stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0] IRQ_PC = PC_W'(INT_VEC);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

    // Return addresses are data: no reset, contents are don't-care until pushed
    logic [PC_W-1:0] stack [STACK_DEPTH];

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_flow;
    logic [PC_W-1:0] stack_top;
    logic [SP_W-1:0] sp_dec;
    logic [SP_W-1:0] sp_inc;
    logic            push;
    logic [PC_W-1:0] push_data;
    logic            irq_take;

    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_MAX);
    assign pc_inc      = pc + PC_W'(1);
    assign pc_flow     = s_inc ? (pc + (s_rel ? imm : PC_W'(1))) : imm;
    assign sp_dec      = sp - SP_W'(1);
    assign sp_inc      = sp + SP_W'(1);
    assign stack_top   = stack[sp_dec[IDX_W-1:0]];

`ifdef PC_SEQ_IRQ_EN
    // Interrupt entry only when no explicit call/ret competes; otherwise it stays pending
    assign irq_take = irq & ~in_isr & ~stack_full & ~s_call & ~s_ret;
`else
    assign irq_take = 1'b0;
`endif

    // Select what gets pushed: call pushes pc+1, interrupt pushes the normal-flow target
    always_comb begin
        push      = 1'b0;
        push_data = pc_inc;
        if (en && !s_ret) begin
            if (s_call) begin
                push = ~stack_full;
            end else if (irq_take) begin
                push      = 1'b1;
                push_data = pc_flow;
            end
        end
    end

    // Stack storage write at the current top slot
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp[IDX_W-1:0]] <= push_data;
        end
    end

    // PC, stack pointer and flags; ret has priority over call over normal flow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RST_PC;
            sp        <= '0;
            stack_err <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
            in_isr    <= 1'b0;
            irq_ack   <= 1'b0;
`endif
        end else begin
`ifdef PC_SEQ_IRQ_EN
            irq_ack <= 1'b0;
`endif
            if (en) begin
                if (s_ret) begin
`ifdef PC_SEQ_IRQ_EN
                    in_isr <= 1'b0;
`endif
                    if (!stack_empty) begin
                        pc <= stack_top;
                        sp <= sp_dec;
                    end else begin
                        pc        <= pc_inc;
                        stack_err <= 1'b1;
                    end
                end else if (s_call) begin
                    if (!stack_full) begin
                        pc <= imm;
                        sp <= sp_inc;
                    end else begin
                        pc        <= pc_inc;
                        stack_err <= 1'b1;
                    end
                end else if (irq_take) begin
                    pc <= IRQ_PC;
                    sp <= sp_inc;
`ifdef PC_SEQ_IRQ_EN
                    in_isr  <= 1'b1;
                    irq_ack <= 1'b1;
`endif
                end else begin
                    pc <= pc_flow;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: two instances (depth 8 and depth 2) share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_pc_seq;

    localparam int PW = 10;
`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, en, s_inc, s_rel, s_call, s_ret;
    logic [PW-1:0] imm;
    logic          irq = 1'b0;
    logic [PW-1:0] pc_a, pc_b;
    logic [3:0]    sp_a;
    logic [1:0]    sp_b;
    logic          emp_a, full_a, err_a, emp_b, full_b, err_b;
`ifdef PC_SEQ_IRQ_EN
    logic          ack_a, isr_a, ack_b, isr_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_seq #(.PC_W(PW), .STACK_DEPTH(8), .RESET_VEC(0), .INT_VEC(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .s_inc(s_inc), .s_rel(s_rel),
        .s_call(s_call), .s_ret(s_ret), .imm(imm),
`ifdef PC_SEQ_IRQ_EN
        .irq(irq), .irq_ack(ack_a), .in_isr(isr_a),
`endif
        .pc(pc_a), .sp(sp_a), .stack_empty(emp_a), .stack_full(full_a),
        .stack_err(err_a)
    );

    pc_seq #(.PC_W(PW), .STACK_DEPTH(2), .RESET_VEC(0), .INT_VEC(1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .s_inc(s_inc), .s_rel(s_rel),
        .s_call(s_call), .s_ret(s_ret), .imm(imm),
`ifdef PC_SEQ_IRQ_EN
        .irq(irq), .irq_ack(ack_b), .in_isr(isr_b),
`endif
        .pc(pc_b), .sp(sp_b), .stack_empty(emp_b), .stack_full(full_b),
        .stack_err(err_b)
    );

    // Behavioural model: one PC, a return-address array and flags per instance
    int            depth [2] = '{8, 2};
    logic [PW-1:0] m_pc  [2];
    int            m_sp  [2];
    bit            m_err [2];
    bit            m_isr [2];
    bit            m_ack [2];
    logic [PW-1:0] m_stk [2][8];
    bit            m_valid = 1'b0;

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = '0; m_sp[k] = 0; m_err[k] = 0; m_isr[k] = 0; m_ack[k] = 0;
        end
    endtask

    task automatic m_step();
        for (int k = 0; k < 2; k++) begin
            logic [PW-1:0] flow;
            bit            room;
            m_ack[k] = 1'b0;
            room     = (m_sp[k] < depth[k]);
            flow     = s_inc ? (m_pc[k] + (s_rel ? imm : PW'(1))) : imm;
            if (en) begin
                if (s_ret) begin
                    m_isr[k] = 1'b0;
                    if (m_sp[k] > 0) begin
                        m_sp[k] = m_sp[k] - 1;
                        m_pc[k] = m_stk[k][m_sp[k]];
                    end else begin
                        m_pc[k]  = m_pc[k] + PW'(1);
                        m_err[k] = 1'b1;
                    end
                end else if (s_call) begin
                    if (room) begin
                        m_stk[k][m_sp[k]] = m_pc[k] + PW'(1);
                        m_sp[k] = m_sp[k] + 1;
                        m_pc[k] = imm;
                    end else begin
                        m_pc[k]  = m_pc[k] + PW'(1);
                        m_err[k] = 1'b1;
                    end
                end else if (IRQ_ON && irq && !m_isr[k] && room) begin
                    m_stk[k][m_sp[k]] = flow;
                    m_sp[k]  = m_sp[k] + 1;
                    m_pc[k]  = PW'(1);
                    m_isr[k] = 1'b1;
                    m_ack[k] = 1'b1;
                end else begin
                    m_pc[k] = flow;
                end
            end
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", n, act, req);
        end
    endtask

    // Hand-computed value checked against both the DUT and the model
    task automatic pin(input string n, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] lit);
        chk({n, "_dut"}, act, lit);
        chk({n, "_model"}, mdl, lit);
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc_a", 32'(pc_a), 32'(m_pc[0]));
            chk("sp_a", 32'(sp_a), m_sp[0]);
            chk("empty_a", 32'(emp_a), 32'(m_sp[0] == 0));
            chk("full_a", 32'(full_a), 32'(m_sp[0] == 8));
            chk("err_a", 32'(err_a), 32'(m_err[0]));
            chk("pc_b", 32'(pc_b), 32'(m_pc[1]));
            chk("sp_b", 32'(sp_b), m_sp[1]);
            chk("empty_b", 32'(emp_b), 32'(m_sp[1] == 0));
            chk("full_b", 32'(full_b), 32'(m_sp[1] == 2));
            chk("err_b", 32'(err_b), 32'(m_err[1]));
`ifdef PC_SEQ_IRQ_EN
            chk("ack_a", 32'(ack_a), 32'(m_ack[0]));
            chk("isr_a", 32'(isr_a), 32'(m_isr[0]));
            chk("ack_b", 32'(ack_b), 32'(m_ack[1]));
            chk("isr_b", 32'(isr_b), 32'(m_isr[1]));
`endif
        end
    end

    task automatic drv(input bit e, input bit i, input bit r, input bit c, input bit rt,
                       input logic [PW-1:0] im);
        en = e; s_inc = i; s_rel = r; s_call = c; s_ret = rt; imm = im;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        m_step();
    endtask

    // Asynchronous reset pulse landing mid-cycle, discarding the pending update
    task automatic do_reset();
        #2;
        reset   = 1'b0;
        m_valid = 1'b0;
        m_reset();
        #1;
        chk("async_rst_pc_a", 32'(pc_a), 0);
        chk("async_rst_err_a", 32'(err_a), 0);
        chk("async_rst_err_b", 32'(err_b), 0);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        m_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, '0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        m_valid = 1'b1;
        pin("rst_pc", 32'(pc_a), 32'(m_pc[0]), 0);
        pin("rst_sp", 32'(sp_a), m_sp[0], 0);
        chk("rst_empty", 32'(emp_a), 1);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_err", 32'(err_a), 0);

        // Sequential increments
        drv(1, 1, 0, 0, 0, '0);
        cyc(); pin("inc1", 32'(pc_a), 32'(m_pc[0]), 1);
        cyc(); pin("inc2", 32'(pc_a), 32'(m_pc[0]), 2);
        cyc(); pin("inc3", 32'(pc_a), 32'(m_pc[0]), 3);
        chk("inc_sp", 32'(sp_a), 0);
        chk("inc_empty", 32'(emp_a), 1);

        // Absolute load, negative relative step, wrap-around
        drv(1, 0, 0, 0, 0, 10'd5);     cyc(); pin("load5", 32'(pc_a), 32'(m_pc[0]), 5);
        drv(1, 1, 1, 0, 0, 10'h3FE);   cyc(); pin("rel_m2", 32'(pc_a), 32'(m_pc[0]), 3);
        drv(1, 0, 0, 0, 0, 10'd1023);  cyc();
        drv(1, 1, 0, 0, 0, '0);        cyc(); pin("wrap", 32'(pc_a), 32'(m_pc[0]), 0);
        chk("wrap_err", 32'(err_a), 0);

        // Nested calls and returns
        drv(1, 0, 0, 0, 0, 10'd4);     cyc();
        drv(1, 1, 0, 1, 0, 10'd100);   cyc(); pin("call1_pc", 32'(pc_a), 32'(m_pc[0]), 100);
        pin("call1_sp", 32'(sp_a), m_sp[0], 1);
        drv(1, 0, 0, 1, 0, 10'd200);   cyc(); pin("call2_pc", 32'(pc_a), 32'(m_pc[0]), 200);
        pin("call2_sp", 32'(sp_a), m_sp[0], 2);
        drv(1, 0, 0, 0, 1, 10'd0);     cyc(); pin("ret1_pc", 32'(pc_a), 32'(m_pc[0]), 101);
        pin("ret1_sp", 32'(sp_a), m_sp[0], 1);
        cyc(); pin("ret2_pc", 32'(pc_a), 32'(m_pc[0]), 5);
        pin("ret2_sp", 32'(sp_a), m_sp[0], 0);

        // Overflow on the depth-2 instance
        drv(1, 0, 0, 1, 0, 10'd300);   cyc();
        drv(1, 0, 0, 1, 0, 10'd400);   cyc(); chk("b_full2", 32'(full_b), 1);
        drv(1, 0, 0, 1, 0, 10'd500);   cyc();
        pin("ovf_pc_b", 32'(pc_b), 32'(m_pc[1]), 401);
        pin("ovf_sp_b", 32'(sp_b), m_sp[1], 2);
        pin("ovf_err_b", 32'(err_b), 32'(m_err[1]), 1);
        pin("ovf_pc_a", 32'(pc_a), 32'(m_pc[0]), 500);
        chk("ovf_err_a", 32'(err_a), 0);
        drv(1, 1, 0, 0, 0, '0);
        repeat (3) cyc();
        pin("sticky_err_b", 32'(err_b), 32'(m_err[1]), 1);
        pin("sticky_pc_b", 32'(pc_b), 32'(m_pc[1]), 404);
        do_reset();
        chk("rst_clears_err_b", 32'(err_b), 0);

        // Call and ret together: pop only, no error
        drv(1, 0, 0, 1, 0, 10'd50);    cyc(); pin("c50_sp", 32'(sp_a), m_sp[0], 1);
        drv(1, 0, 0, 1, 1, 10'd60);    cyc();
        pin("callret_pc", 32'(pc_a), 32'(m_pc[0]), 1);
        pin("callret_sp", 32'(sp_a), m_sp[0], 0);
        chk("callret_err", 32'(err_a), 0);

        // Underflow
        drv(1, 0, 0, 0, 0, 10'd7);     cyc();
        drv(1, 0, 0, 0, 1, 10'd0);     cyc();
        pin("unf_pc", 32'(pc_a), 32'(m_pc[0]), 8);
        pin("unf_err", 32'(err_a), 32'(m_err[0]), 1);

        // Stall holds everything
        drv(0, 0, 0, 1, 0, 10'd123);
        repeat (2) cyc();
        pin("stall_pc", 32'(pc_a), 32'(m_pc[0]), 8);
        pin("stall_sp", 32'(sp_a), m_sp[0], 0);

`ifdef PC_SEQ_IRQ_EN
        do_reset();
        drv(1, 0, 0, 0, 0, 10'd20);    cyc();
        drv(1, 1, 0, 0, 0, '0); irq = 1'b1;
        cyc();
        pin("irq_pc", 32'(pc_a), 32'(m_pc[0]), 1);
        pin("irq_ack", 32'(ack_a), 32'(m_ack[0]), 1);
        pin("irq_isr", 32'(isr_a), 32'(m_isr[0]), 1);
        cyc();
        pin("irq2_ack", 32'(ack_a), 32'(m_ack[0]), 0);
        pin("irq2_pc", 32'(pc_a), 32'(m_pc[0]), 2);
        irq = 1'b0;
        drv(1, 0, 0, 0, 1, '0);        cyc();
        pin("reti_pc", 32'(pc_a), 32'(m_pc[0]), 21);
        pin("reti_isr", 32'(isr_a), 32'(m_isr[0]), 0);
        drv(0, 1, 0, 0, 0, '0); irq = 1'b1;
        repeat (2) cyc();
        pin("irq_stall_pc", 32'(pc_a), 32'(m_pc[0]), 21);
        drv(1, 1, 0, 0, 0, '0);        cyc();
        pin("irq_late_pc", 32'(pc_a), 32'(m_pc[0]), 1);
        irq = 1'b0;
        drv(1, 0, 0, 0, 1, '0);        cyc();
        pin("irq_late_ret", 32'(pc_a), 32'(m_pc[0]), 22);
`endif

        // Randomised traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            s_inc  = ($urandom_range(0, 3) != 0);
            s_rel  = 1'($urandom_range(0, 1));
            s_call = ($urandom_range(0, 4) == 0);
            s_ret  = ($urandom_range(0, 4) == 0);
            imm    = PW'($urandom);
            irq    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else cyc();
        end

        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
